tmr_arb_ctrl: RTL and testbench
===============================

// Module: tmr_arb_ctrl
// PURPOSE
//  Shares one external 8-bit loadable up-counter (LD/EN/CAI/CAO style) among NREQ requesters.
//  Each requester asks for a delay of LEN clock cycles. The block grants round-robin, loads
//  the counter, enables counting, watches the carry-out and signals DONE to the owner.
//  Sits between timeout/delay clients and the single shared counter macro.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  CW    8  counter width; must match the attached counter
// PORTS
//  CLK      in   1        rising-edge clock
//  RST      in   1        synchronous reset, active-high
//  REQ      in   NREQ     level request per channel; held until DONE or dropped to abort
//  LEN      in   NREQ*CW  delay per channel; slice i = LEN[i*CW +: CW]; sampled at grant
//  GNT      out  NREQ     one-hot owner of counter; all-zero when idle
//  DONE     out  NREQ     one-cycle pulse to owner when its delay expires
//  BUSY     out  1        counter owned (state != IDLE)
//  CNT_D    out  CW       counter parallel-load data
//  CNT_LD   out  1        counter load strobe
//  CNT_EN   out  1        counter enable
//  CNT_CAI  out  1        counter carry-in; equals CNT_EN
//  CNT_CAO  in   1        counter carry-out (CAI & EN & Q all-ones)
// BEHAVIOUR
//  - Reset: state=IDLE, GNT=0, DONE=0, BUSY=0, CNT_LD=0, CNT_EN=CNT_CAI=0, CNT_D=0, rr ptr=0.
//  - FSM: IDLE -> LOAD -> RUN -> FIN -> IDLE.
//   IDLE: if any REQ, pick winner round-robin from ptr (ptr itself is highest priority);
//         register GNT, capture LEN slice, go LOAD. Otherwise stay.
//   LOAD: CNT_LD=1, CNT_D = (2^CW - LEN) mod 2^CW; go RUN.
//   RUN : CNT_EN=CNT_CAI=1. When CNT_CAO=1, go FIN.
//   FIN : DONE[owner]=1 for one cycle, GNT cleared, ptr=owner+1 mod NREQ; go IDLE.
//  - Count: counter steps V..2^CW-1, so RUN lasts exactly LEN cycles. LEN=0 means 2^CW cycles.
//  - Latency: REQ seen in IDLE at cycle t -> GNT at t+1 -> RUN t+2..t+1+LEN -> DONE at t+2+LEN.
//  - Back-to-back: min 1 IDLE cycle between jobs. A REQ still high in the IDLE after FIN is a
//    new request, but that channel now has lowest priority.
//  - Abort: owner REQ low in LOAD or RUN -> next state IDLE, GNT=0, CNT_EN=0, no DONE,
//    ptr advances past owner. Abort beats CNT_CAO in the same cycle.
//  - REQ of non-owners is ignored until IDLE. LEN changes after grant are ignored.
//  - RST mid-job: returns to reset values next edge, no DONE. Counter content is left as is;
//    the next LOAD overwrites it.
//  - All outputs are registered.
// CONFIGURATION
//  TMR_ARB_PAUSE_EN defined: adds input PAUSE (1 bit). In RUN, PAUSE=1 forces CNT_EN=CNT_CAI=0.
//    The count is frozen and RUN is extended one cycle per paused cycle. CNT_CAO cannot fire
//    while paused. PAUSE has no effect in other states.
//  Not defined: no PAUSE port; RUN always counts.
// STRUCTURE
//  Shared package/include tmr_arb_pkg: state encodings (ST_IDLE/ST_LOAD/ST_RUN/ST_FIN, 2 bits),
//    default CW and NREQ constants.
//  Sub-module rr_arb (NREQ-wide round-robin picker, combinational: req, ptr -> one-hot gnt).
//    It is instantiated once. FSM, counter interface and registers stay in tmr_arb_ctrl.
//  Bench pairs the block with the 8-bit counter macro (CD=SD=0) as the shared resource.
// TESTING
//  1. REQ[0]=1, LEN0=5 -> GNT=0001 at t+1, CNT_D=251 with CNT_LD, 5 RUN cycles, DONE[0] at t+7.
//  2. REQ=1111 held, all LEN=2 -> grants 0,1,2,3,0 in order. Each DONE pulse once per job.
//     One IDLE cycle between jobs.
//  3. LEN=0 on ch2 -> CNT_D=0, RUN lasts 256 cycles, DONE[2] once; LEN=1 -> CNT_D=255, RUN 1.
//  4. Abort: ch1 LEN=10, drop REQ[1] in RUN cycle 4 -> GNT=0, CNT_EN=0 next cycle, no DONE.
//     Waiting ch2 granted next.
//  5. RST pulse during RUN -> all outputs 0, state IDLE next cycle; later REQ served normally.
//  6. (TMR_ARB_PAUSE_EN) LEN=4, PAUSE high 3 cycles in RUN -> DONE delayed by exactly 3 cycles.

Source files
------------

// File: rtl/tmr_arb_pkg.sv
// Purpose: shared FSM state encodings and default sizes for the shared-timer arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tmr_arb_pkg;

  // Default number of requesters and counter width
  localparam int TMR_NREQ = 4;
  localparam int TMR_CW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } tmr_state_t;

endpackage

// File: rtl/tmr_arb_ctrl_if.sv
// Purpose: groups the requester side (REQ/LEN/GNT/DONE/BUSY) and the counter side
//   (CNT_D/CNT_LD/CNT_EN/CNT_CAI/CNT_CAO) of the shared-timer arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; slave = tmr_arb_ctrl, master = clients plus counter macro.
interface tmr_arb_ctrl_if
  import tmr_arb_pkg::*;
#(
  parameter int NREQ = TMR_NREQ,
  parameter int CW   = TMR_CW
);

  logic [NREQ-1:0]    REQ;
  logic [NREQ*CW-1:0] LEN;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    DONE;
  logic               BUSY;
  logic [CW-1:0]      CNT_D;
  logic               CNT_LD;
  logic               CNT_EN;
  logic               CNT_CAI;
  logic               CNT_CAO;

  modport slave (
    input  REQ, LEN, CNT_CAO,
    output GNT, DONE, BUSY, CNT_D, CNT_LD, CNT_EN, CNT_CAI
  );

  modport master (
    output REQ, LEN, CNT_CAO,
    input  GNT, DONE, BUSY, CNT_D, CNT_LD, CNT_EN, CNT_CAI
  );

endinterface

// File: rtl/tmr_arb_ctrl_rr_arb.sv
// Purpose: combinational round-robin picker; ptr channel has highest priority, then ptr+1, ...
// Latency: 0 cycles (pure combinational).
// Backpressure: none; gnt is all-zero when no request is pending.
// Ports: req (NREQ level requests), ptr (priority start index), gnt (one-hot winner).
module rr_arb
  import tmr_arb_pkg::*;
#(
  parameter int NREQ = TMR_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    // Walk the channels starting at ptr, wrapping once; the first requester wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_arb_ctrl.sv
// Purpose: shares one loadable up-counter among NREQ delay requesters (round-robin grant,
//   load with 2^CW-LEN, count until carry-out, one-cycle DONE to the owner).
// Latency: REQ in IDLE at t -> GNT/CNT_LD at t+1 -> RUN t+2..t+1+LEN -> DONE at t+2+LEN.
// Backpressure: owner holds REQ for the whole job; dropping it aborts (no DONE).
// Ports: CLK, RST (sync, active-high); bus (tmr_arb_ctrl_if.slave) carries REQ/LEN/GNT/DONE/
//   BUSY and the counter strobes CNT_D/CNT_LD/CNT_EN/CNT_CAI/CNT_CAO.
// Option: define TMR_ARB_PAUSE_EN to add input PAUSE, which freezes the count while in RUN.
module tmr_arb_ctrl
  import tmr_arb_pkg::*;
#(
  parameter int NREQ = TMR_NREQ,
  parameter int CW   = TMR_CW
) (
  input  logic CLK,
  input  logic RST,
`ifdef TMR_ARB_PAUSE_EN
  input  logic PAUSE,
`endif
  tmr_arb_ctrl_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  tmr_state_t      state_q, state_nxt;
  logic [NREQ-1:0] gnt_q, gnt_nxt;
  logic [NREQ-1:0] done_q, done_nxt;
  logic            busy_q, busy_nxt;
  logic [CW-1:0]   cnt_d_q, cnt_d_nxt;
  logic            cnt_ld_q, cnt_ld_nxt;
  logic            cnt_en_q, cnt_en_nxt;
  logic [PW-1:0]   ptr_q, ptr_nxt;
  logic [PW-1:0]   owner_q, owner_nxt;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic [CW-1:0]   pick_len;
  logic [PW-1:0]   ptr_after_owner;
  logic            owner_req;

  rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arb (
    .req (bus.REQ),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Index and LEN slice of the winning channel (pick is one-hot or zero).
  always_comb begin
    pick_idx = '0;
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
        pick_len = bus.LEN[i*CW +: CW];
      end
    end
  end

  assign ptr_after_owner = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_req       = |(bus.REQ & gnt_q);

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt  = state_q;
    gnt_nxt    = gnt_q;
    done_nxt   = '0;
    cnt_d_nxt  = cnt_d_q;
    cnt_ld_nxt = 1'b0;
    cnt_en_nxt = 1'b0;
    ptr_nxt    = ptr_q;
    owner_nxt  = owner_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.REQ) begin
          state_nxt  = ST_LOAD;
          gnt_nxt    = pick;
          owner_nxt  = pick_idx;
          // Start value so the counter reaches all-ones after exactly LEN steps;
          // LEN=0 wraps to 0 and gives the full 2^CW cycles.
          cnt_d_nxt  = '0 - pick_len;
          cnt_ld_nxt = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after_owner;
        end else begin
          state_nxt  = ST_RUN;
          cnt_en_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort is checked first so it wins over a carry-out in the same cycle.
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after_owner;
        end else if (bus.CNT_CAO) begin
          state_nxt = ST_FIN;
          gnt_nxt   = '0;
          done_nxt  = gnt_q;
          ptr_nxt   = ptr_after_owner;
        end else begin
          cnt_en_nxt = 1'b1;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cnt_d_q  <= '0;
      cnt_ld_q <= 1'b0;
      cnt_en_q <= 1'b0;
      ptr_q    <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_nxt;
      gnt_q    <= gnt_nxt;
      done_q   <= done_nxt;
      busy_q   <= busy_nxt;
      cnt_d_q  <= cnt_d_nxt;
      cnt_ld_q <= cnt_ld_nxt;
      cnt_en_q <= cnt_en_nxt;
      ptr_q    <= ptr_nxt;
      owner_q  <= owner_nxt;
    end
  end

  assign bus.GNT    = gnt_q;
  assign bus.DONE   = done_q;
  assign bus.BUSY   = busy_q;
  assign bus.CNT_D  = cnt_d_q;
  assign bus.CNT_LD = cnt_ld_q;

`ifdef TMR_ARB_PAUSE_EN
  // PAUSE gates the enable directly so the counter (and its carry-out) freezes in the
  // same cycle; cnt_en_q is only ever set while in RUN, so PAUSE is inert elsewhere.
  assign bus.CNT_EN  = cnt_en_q & ~PAUSE;
  assign bus.CNT_CAI = cnt_en_q & ~PAUSE;
`else
  assign bus.CNT_EN  = cnt_en_q;
  assign bus.CNT_CAI = cnt_en_q;
`endif

endmodule

// File: tb/tb_tmr_arb_ctrl.sv
// Purpose: directed self-checking bench for tmr_arb_ctrl paired with a model of the
//   8-bit loadable up-counter macro (clear/set tied off).
// Latency/backpressure: inputs driven and outputs sampled on the falling clock edge.
module tb_tmr_arb_ctrl;
  import tmr_arb_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
`ifdef TMR_ARB_PAUSE_EN
  logic PAUSE = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  tmr_arb_ctrl_if #(.NREQ(4), .CW(8)) bus_if ();

  tmr_arb_ctrl #(.NREQ(4), .CW(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
`ifdef TMR_ARB_PAUSE_EN
    .PAUSE (PAUSE),
`endif
    .bus   (bus_if.slave)
  );

  always #5 CLK = ~CLK;

  // Shared counter macro: load has priority, counts when EN & CAI, carry-out at all-ones.
  logic [7:0] cnt_q = 8'd0;
  always_ff @(posedge CLK) begin
    if (bus_if.CNT_LD) cnt_q <= bus_if.CNT_D;
    else if (bus_if.CNT_EN && bus_if.CNT_CAI) cnt_q <= cnt_q + 8'd1;
  end
  assign bus_if.CNT_CAO = bus_if.CNT_CAI & bus_if.CNT_EN & (&cnt_q);

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus_if.REQ = '0;
    bus_if.LEN = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus_if.REQ = 4'b1111;
    bus_if.LEN = '0;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.DONE, bus_if.BUSY, bus_if.CNT_LD, bus_if.CNT_EN, bus_if.CNT_CAI, bus_if.CNT_D} !== 20'd0)
      $display("FAIL reset_outputs got gnt=%b done=%b busy=%b ld=%b en=%b cai=%b d=%0d want all 0",
               bus_if.GNT, bus_if.DONE, bus_if.BUSY, bus_if.CNT_LD, bus_if.CNT_EN, bus_if.CNT_CAI, bus_if.CNT_D);
    else passed++;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.BUSY} !== 5'd0)
      $display("FAIL reset_hold_no_grant got gnt=%b busy=%b want 0", bus_if.GNT, bus_if.BUSY);
    else passed++;
    bus_if.REQ = '0;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus_if.LEN[0 +: 8] = 8'd5;
    bus_if.REQ = 4'b0001;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D, bus_if.BUSY} !== {4'b0001, 1'b1, 8'd251, 1'b1})
      $display("FAIL single_load got gnt=%b ld=%b d=%0d busy=%b want 0001 1 251 1",
               bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D, bus_if.BUSY);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus_if.CNT_EN, bus_if.CNT_CAI, bus_if.DONE, bus_if.CNT_LD} !== {1'b1, 1'b1, 4'b0000, 1'b0})
        $display("FAIL single_run%0d got en=%b cai=%b done=%b ld=%b want 1 1 0000 0",
                 i, bus_if.CNT_EN, bus_if.CNT_CAI, bus_if.DONE, bus_if.CNT_LD);
      else passed++;
    end
    tick();
    total++;
    if ({bus_if.DONE, bus_if.GNT, bus_if.CNT_EN, bus_if.BUSY} !== {4'b0001, 4'b0000, 1'b0, 1'b1})
      $display("FAIL single_done got done=%b gnt=%b en=%b busy=%b want 0001 0000 0 1",
               bus_if.DONE, bus_if.GNT, bus_if.CNT_EN, bus_if.BUSY);
    else passed++;
    bus_if.REQ = '0;
    tick();
    total++;
    if ({bus_if.DONE, bus_if.BUSY} !== 5'd0)
      $display("FAIL single_idle got done=%b busy=%b want 0000 0", bus_if.DONE, bus_if.BUSY);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) bus_if.LEN[i*8 +: 8] = 8'd2;
    bus_if.REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      tick();
      total++;
      if ({bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D} !== {exp, 1'b1, 8'd254})
        $display("FAIL b2b_grant%0d got gnt=%b ld=%b d=%0d want %b 1 254",
                 k, bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D, exp);
      else passed++;
      for (int r = 0; r < 2; r++) begin
        tick();
        total++;
        if ({bus_if.CNT_EN, bus_if.GNT, bus_if.DONE} !== {1'b1, exp, 4'b0000})
          $display("FAIL b2b_run%0d_%0d got en=%b gnt=%b done=%b want 1 %b 0000",
                   k, r, bus_if.CNT_EN, bus_if.GNT, bus_if.DONE, exp);
        else passed++;
      end
      tick();
      total++;
      if ({bus_if.DONE, bus_if.GNT} !== {exp, 4'b0000})
        $display("FAIL b2b_done%0d got done=%b gnt=%b want %b 0000", k, bus_if.DONE, bus_if.GNT, exp);
      else passed++;
      if (k == 4) bus_if.REQ = '0;
      tick();
      total++;
      if ({bus_if.BUSY, bus_if.GNT, bus_if.DONE} !== 9'd0)
        $display("FAIL b2b_gap%0d got busy=%b gnt=%b done=%b want 0 0000 0000",
                 k, bus_if.BUSY, bus_if.GNT, bus_if.DONE);
      else passed++;
    end
  endtask

  task automatic test_len_edges();
    int n;
    do_reset();
    bus_if.LEN[16 +: 8] = 8'd0;
    bus_if.REQ = 4'b0100;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D} !== {4'b0100, 1'b1, 8'd0})
      $display("FAIL len0_load got gnt=%b ld=%b d=%0d want 0100 1 0", bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D);
    else passed++;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus_if.DONE !== 4'b0000) break;
      if (bus_if.CNT_EN === 1'b1) n++;
    end
    total++;
    if (bus_if.DONE !== 4'b0100)
      $display("FAIL len0_done got done=%b want 0100 (timeout or wrong owner)", bus_if.DONE);
    else passed++;
    total++;
    if (n !== 256) $display("FAIL len0_run_cycles got %0d want 256", n);
    else passed++;
    bus_if.REQ = '0;
    tick();
    total++;
    if (bus_if.DONE !== 4'b0000) $display("FAIL len0_single_pulse got done=%b want 0000", bus_if.DONE);
    else passed++;
    bus_if.LEN[16 +: 8] = 8'd1;
    bus_if.REQ = 4'b0100;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_D} !== {4'b0100, 8'd255})
      $display("FAIL len1_load got gnt=%b d=%0d want 0100 255", bus_if.GNT, bus_if.CNT_D);
    else passed++;
    tick();
    total++;
    if ({bus_if.CNT_EN, bus_if.DONE} !== {1'b1, 4'b0000})
      $display("FAIL len1_run got en=%b done=%b want 1 0000", bus_if.CNT_EN, bus_if.DONE);
    else passed++;
    tick();
    total++;
    if ({bus_if.DONE, bus_if.CNT_EN} !== {4'b0100, 1'b0})
      $display("FAIL len1_done got done=%b en=%b want 0100 0", bus_if.DONE, bus_if.CNT_EN);
    else passed++;
    bus_if.REQ = '0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    bus_if.LEN[8 +: 8] = 8'd10;
    bus_if.REQ = 4'b0010;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_D} !== {4'b0010, 8'd246})
      $display("FAIL abort_load got gnt=%b d=%0d want 0010 246", bus_if.GNT, bus_if.CNT_D);
    else passed++;
    for (int r = 1; r <= 4; r++) begin
      tick();
      if (r == 1) begin
        bus_if.LEN[0 +: 8]  = 8'd2;
        bus_if.LEN[16 +: 8] = 8'd3;
        bus_if.REQ = 4'b0111;
      end
      if (r >= 2) begin
        total++;
        if ({bus_if.GNT, bus_if.CNT_EN} !== {4'b0010, 1'b1})
          $display("FAIL abort_owner_kept%0d got gnt=%b en=%b want 0010 1", r, bus_if.GNT, bus_if.CNT_EN);
        else passed++;
      end
    end
    bus_if.REQ = 4'b0101;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_EN, bus_if.DONE, bus_if.BUSY} !== 10'd0)
      $display("FAIL abort_idle got gnt=%b en=%b done=%b busy=%b want 0000 0 0000 0",
               bus_if.GNT, bus_if.CNT_EN, bus_if.DONE, bus_if.BUSY);
    else passed++;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_D} !== {4'b0100, 8'd253})
      $display("FAIL abort_next_grant got gnt=%b d=%0d want 0100 253", bus_if.GNT, bus_if.CNT_D);
    else passed++;
    repeat (3) tick();
    tick();
    total++;
    if (bus_if.DONE !== 4'b0100) $display("FAIL abort_ch2_done got done=%b want 0100", bus_if.DONE);
    else passed++;
    bus_if.REQ = 4'b0001;
    tick();
    tick();
    total++;
    if (bus_if.GNT !== 4'b0001) $display("FAIL abort_ch0_grant got gnt=%b want 0001", bus_if.GNT);
    else passed++;
    bus_if.REQ = '0;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_EN, bus_if.DONE, bus_if.BUSY} !== 10'd0)
      $display("FAIL abort_in_load got gnt=%b en=%b done=%b busy=%b want all 0",
               bus_if.GNT, bus_if.CNT_EN, bus_if.DONE, bus_if.BUSY);
    else passed++;
  endtask

  task automatic test_rst_mid_job();
    do_reset();
    bus_if.LEN[24 +: 8] = 8'd20;
    bus_if.REQ = 4'b1000;
    tick();
    repeat (3) tick();
    RST = 1'b1;
    bus_if.REQ = '0;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.DONE, bus_if.BUSY, bus_if.CNT_LD, bus_if.CNT_EN, bus_if.CNT_CAI, bus_if.CNT_D} !== 20'd0)
      $display("FAIL rst_mid_outputs got gnt=%b done=%b busy=%b ld=%b en=%b cai=%b d=%0d want all 0",
               bus_if.GNT, bus_if.DONE, bus_if.BUSY, bus_if.CNT_LD, bus_if.CNT_EN, bus_if.CNT_CAI, bus_if.CNT_D);
    else passed++;
    RST = 1'b0;
    bus_if.LEN[8 +: 8] = 8'd3;
    bus_if.REQ = 4'b0010;
    tick();
    total++;
    if ({bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D} !== {4'b0010, 1'b1, 8'd253})
      $display("FAIL rst_after_load got gnt=%b ld=%b d=%0d want 0010 1 253", bus_if.GNT, bus_if.CNT_LD, bus_if.CNT_D);
    else passed++;
    repeat (3) tick();
    tick();
    total++;
    if (bus_if.DONE !== 4'b0010) $display("FAIL rst_after_done got done=%b want 0010", bus_if.DONE);
    else passed++;
    bus_if.REQ = '0;
    tick();
  endtask

`ifdef TMR_ARB_PAUSE_EN
  task automatic test_pause();
    int n;
    do_reset();
    bus_if.LEN[0 +: 8] = 8'd4;
    bus_if.REQ = 4'b0001;
    tick();
    n = 0;
    for (int c = 1; c < 40; c++) begin
      tick();
      if (c == 2) PAUSE = 1'b1;
      if (c == 5) PAUSE = 1'b0;
      if (bus_if.DONE !== 4'b0000) begin
        n = c;
        break;
      end
    end
    PAUSE = 1'b0;
    total++;
    if (n !== 8) $display("FAIL pause_done_cycle got %0d want 8", n);
    else passed++;
    bus_if.REQ = '0;
    tick();
  endtask
`endif

  initial begin
    bus_if.REQ = '0;
    bus_if.LEN = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_len_edges();
    test_abort();
    test_rst_mid_job();
`ifdef TMR_ARB_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d of %0d checks", passed, total);
    $fatal(1);
  end

endmodule
